// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the writeback / decode boundary of the scalar pipe.
//   Provides the default register-file geometry, the register-address and
//   data-word types, and the hard-wired zero register index.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Default register-file geometry.
  localparam int RF_NREGS = 16;
  localparam int RF_DW    = 32;
  localparam int RF_PW    = 2;

  // Register address width and types derived from the default geometry.
  localparam int REG_AW = $clog2(RF_NREGS);

  typedef logic [REG_AW-1:0] regaddr_t;
  typedef logic [RF_DW-1:0]  word_t;

  // Register 0 always reads as zero and never accepts writes.
  localparam regaddr_t ZERO_REG = '0;

endpackage : pipe_pkg

// File: rtl/pending_ctr.sv
// -----------------------------------------------------------------------------
// pending_ctr
//   Saturating up/down counter tracking how many issued-but-not-yet-written-back
//   instructions target one register.
//
//   Ports
//     clk      in   clock, state updates on the rising edge
//     rst      in   synchronous active-low reset, clears the count
//     inc      in   an instruction targeting this register was issued
//     dec      in   a writeback to this register committed
//     cnt      out  current outstanding-write count (PW bits)
//     nonzero  out  cnt != 0
// -----------------------------------------------------------------------------
module pending_ctr #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] cnt,
  output logic          nonzero
);

  localparam logic [PW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] CNT_ZERO = '0;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // An issue and a writeback in the same cycle cancel each other. The upper
  // clamp is a safety net: decode already stalls a full counter. The lower
  // clamp absorbs writebacks that were never tracked (e.g. after a reset).
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + PW'(1);
    end else if (dec && !inc && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != CNT_ZERO);

endmodule : pending_ctr

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Architectural scalar register file at the end of the writeback path.
//   Commits the selected writeback word, serves two combinational read ports
//   to decode with same-cycle write-through bypass, and keeps a per-register
//   pending-write scoreboard that produces the decode stall for
//   read-after-write and counter-overflow hazards.
//
//   Ports
//     clk        in   clock, all state updates on the rising edge
//     rst        in   synchronous active-low reset
//     wb_we      in   writeback commit strobe
//     wb_wa      in   writeback destination register
//     WriteData  in   writeback data
//     iss_valid  in   decode issues this cycle (accepted only when stall=0)
//     iss_we     in   issued instruction writes a register
//     iss_wa     in   destination of the issued instruction
//     ra1, ra2   in   read addresses
//     rd1, rd2   out  read data (zero for r0, bypassed from writeback)
//     stall      out  decode must hold, the issue is not accepted
//     busy_mask  out  bit i set while register i has writes outstanding
// -----------------------------------------------------------------------------
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int DW    = RF_DW,
  parameter int PW    = RF_PW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [$clog2(NREGS)-1:0] wb_wa,
  input  logic [DW-1:0]            WriteData,
  input  logic                     iss_valid,
  input  logic                     iss_we,
  input  logic [$clog2(NREGS)-1:0] iss_wa,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic [DW-1:0]            rd1,
  output logic [DW-1:0]            rd2,
  output logic                     stall,
  output logic [NREGS-1:0]         busy_mask
);

  localparam int AW = $clog2(NREGS);

  localparam logic [AW-1:0] R0      = AW'(ZERO_REG);
  localparam logic [PW-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0] CNT_ONE = PW'(1);

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  logic wb_commit;
  assign wb_commit = wb_we && (wb_wa != R0);

  always_comb begin
    regs_d = regs_q;
    if (wb_commit) begin
      regs_d[wb_wa] = WriteData;
    end
  end

  // Reset is sampled before the write, so a writeback landing in the reset
  // cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    rd1 = regs_q[ra1];
    if (wb_we && (wb_wa == ra1)) begin
      rd1 = WriteData;
    end
    if (ra1 == R0) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = regs_q[ra2];
    if (wb_we && (wb_wa == ra2)) begin
      rd2 = WriteData;
    end
    if (ra2 == R0) begin
      rd2 = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [NREGS-1:0][PW-1:0] cnt_vec;
  logic [NREGS-1:0]         dec_vec;
  logic                     iss_ok;

  // One-hot writeback decrement; bit 0 is never set.
  always_comb begin
    dec_vec = '0;
    if (wb_commit) begin
      dec_vec[wb_wa] = 1'b1;
    end
  end

  // Kept separate from dec_vec: stall depends on dec_vec, and iss_ok depends
  // on stall.
  assign iss_ok = iss_valid && !stall && iss_we && (iss_wa != R0);

  assign cnt_vec[0]   = '0;
  assign busy_mask[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_ctr
    pending_ctr #(
      .PW(PW)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc    (iss_ok && (iss_wa == AW'(i))),
      .dec    (dec_vec[i]),
      .cnt    (cnt_vec[i]),
      .nonzero(busy_mask[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------

  // A source is still in flight unless its only outstanding write is the one
  // committing right now, which the bypass already delivers.
  function automatic logic raw_hazard(input logic [PW-1:0] cnt, input logic dec);
    return (cnt != '0) && !((cnt == CNT_ONE) && dec);
  endfunction

  logic hz_ra1;
  logic hz_ra2;
  logic hz_full;

  always_comb begin
    hz_ra1  = raw_hazard(cnt_vec[ra1], dec_vec[ra1]);
    hz_ra2  = raw_hazard(cnt_vec[ra2], dec_vec[ra2]);
    // A full counter only blocks a new issue if no slot frees up this cycle.
    hz_full = iss_we && (cnt_vec[iss_wa] == CNT_MAX) && !dec_vec[iss_wa];
    stall   = iss_valid && (hz_ra1 || hz_ra2 || hz_full);
  end

endmodule : wb_regfile
